// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and load/store.
// Data has priority unless fetch has lost STARVE_MAX issue slots in a row; misaligned data is rejected locally.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_ctrl,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [2:0]            mem_ctrl,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_if,
  output logic                  stall_d
);

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_ONE    = LW'(1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] lsb);
    case (ctrl)
      MEM_H, MEM_HU: misaligned = lsb[0];
      MEM_W:         misaligned = (lsb != 2'b00);
      MEM_B, MEM_BU: misaligned = 1'b0;
      default:       misaligned = 1'b0;
    endcase
  endfunction

  state_t          state, next_state;
  owner_t          owner, owner_next;
  logic [LW-1:0]   lat_cnt, lat_next;
  logic [SW-1:0]   starve_cnt, starve_next;
  logic            err_q, err_next;
  logic            resp, issue_slot, d_wins, f_wins;

  // A response cycle is the last count of an outstanding transaction.
  assign resp      = (state == ST_WAIT) && (lat_cnt == LAT_ONE);
  assign if_rvalid = resp && (owner == OWN_IF);
  assign d_rvalid  = resp && (owner == OWN_D);
  assign d_err     = err_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !err_q) ? mem_rdata : '0;
  assign stall_if  = if_req & ~if_rvalid;
  assign stall_d   = d_req & ~d_rvalid;

  // Arbitration, memory-port drive and next-state selection.
  always_comb begin
    next_state  = state;
    owner_next  = owner;
    lat_next    = lat_cnt;
    starve_next = starve_cnt;
    err_next    = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_ctrl    = 3'b000;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wins      = 1'b0;
    f_wins      = 1'b0;

    // The rejection cycle of a misaligned access is never an issue slot.
    issue_slot = rst_n && ((state == ST_IDLE) || (resp && !err_q));

    if (state == ST_WAIT) begin
      if (lat_cnt == LAT_ONE) begin
        next_state = ST_IDLE;
        lat_next   = '0;
      end else begin
        lat_next = lat_cnt - LAT_ONE;
      end
    end else begin
      lat_next = '0;
    end

    if (issue_slot) begin
      if (d_req && (starve_cnt < STARVE_LIM)) begin
        d_wins = 1'b1;
      end else if (if_req) begin
        f_wins = 1'b1;
      end else if (d_req) begin
        d_wins = 1'b1;
      end else begin
        d_wins = 1'b0;
      end

      if (f_wins) begin
        if_gnt      = 1'b1;
        mem_en      = 1'b1;
        mem_ctrl    = MEM_W;
        mem_addr    = if_addr;
        next_state  = ST_WAIT;
        owner_next  = OWN_IF;
        lat_next    = LAT_LOAD;
        starve_next = '0;
      end else if (d_wins) begin
        d_gnt      = 1'b1;
        next_state = ST_WAIT;
        owner_next = OWN_D;
        if (if_req) begin
          starve_next = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + SW'(1);
        end else begin
          starve_next = '0;
        end
        if (misaligned(d_ctrl, d_addr[1:0])) begin
          lat_next = LAT_ONE;
          err_next = 1'b1;
        end else begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_ctrl  = d_ctrl;
          mem_addr  = d_addr;
          mem_wdata = d_we ? d_wdata : '0;
          lat_next  = LAT_LOAD;
        end
      end else begin
        starve_next = '0;
      end
    end else begin
      starve_next = starve_cnt;
    end
  end

  // State, owner and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= next_state;
      owner      <= owner_next;
      lat_cnt    <= lat_next;
      starve_cnt <= starve_next;
      err_q      <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_MAX=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_HU = 3'b101;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_ctrl;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_d;

  int n_cmp, n_bad;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_ctrl(d_ctrl), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_in();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_ctrl = MEM_W; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0;
  endtask

  logic [7:0] s_ireq, s_dreq, s_dg, s_ig, s_dv, s_iv;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    idle_in();
    if_req = 1'b1;

    // Reset: every output low even with a request pending; stall follows its equation.
    step(); step(); sample();
    check("rst_if_gnt",   32'(if_gnt),    32'd0);
    check("rst_mem_en",   32'(mem_en),    32'd0);
    check("rst_if_rvalid",32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid),  32'd0);
    check("rst_d_err",    32'(d_err),     32'd0);
    check("rst_if_rdata", if_rdata,       32'd0);
    check("rst_mem_addr", mem_addr,       32'd0);
    check("rst_stall_if", 32'(stall_if),  32'd1);
    step(); if_req = 1'b0; rst_n = 1'b1;

    // Single fetch, followed by a back-to-back fetch in the response cycle.
    step(); if_req = 1'b1; if_addr = 32'h100;
    sample();
    check("f1_gnt",      32'(if_gnt),   32'd1);
    check("f1_mem_en",   32'(mem_en),   32'd1);
    check("f1_addr",     mem_addr,      32'h100);
    check("f1_ctrl",     32'(mem_ctrl), 32'(MEM_W));
    check("f1_we",       32'(mem_we),   32'd0);
    check("f1_stall_c1", 32'(stall_if), 32'd1);
    step(); sample();
    check("f1_gnt_c2",   32'(if_gnt),   32'd0);
    check("f1_idle_addr",mem_addr,      32'd0);
    check("f1_stall_c2", 32'(stall_if), 32'd1);
    step(); if_addr = 32'h104; mem_rdata = 32'hDEADBEEF;
    sample();
    check("f1_rvalid",   32'(if_rvalid),32'd1);
    check("f1_rdata",    if_rdata,      32'hDEADBEEF);
    check("f1_stall_c3", 32'(stall_if), 32'd0);
    check("f2_gnt",      32'(if_gnt),   32'd1);
    check("f2_addr",     mem_addr,      32'h104);
    step(); mem_rdata = 32'h0;
    sample();
    check("f2_gnt_c4",   32'(if_gnt),   32'd0);
    check("f2_stall_c4", 32'(stall_if), 32'd1);
    step(); if_req = 1'b0; mem_rdata = 32'h12345678;
    sample();
    check("f2_rvalid",   32'(if_rvalid),32'd1);
    check("f2_rdata",    if_rdata,      32'h12345678);
    check("f2_mem_en",   32'(mem_en),   32'd0);
    step(); mem_rdata = 32'h0;
    sample();
    check("f2_rvalid_off",32'(if_rvalid),32'd0);

    // Simultaneous requests: data first, fetch issued in data's response cycle.
    step(); if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_ctrl = MEM_W; d_addr = 32'h200;
    sample();
    check("sim_d_gnt",   32'(d_gnt),    32'd1);
    check("sim_if_gnt0", 32'(if_gnt),   32'd0);
    check("sim_addr",    mem_addr,      32'h200);
    step(); sample();
    check("sim_d_gnt_c2",32'(d_gnt),    32'd0);
    check("sim_if_gnt_c2",32'(if_gnt),  32'd0);
    step(); d_req = 1'b0; mem_rdata = 32'hCAFE0001;
    sample();
    check("sim_d_rvalid",32'(d_rvalid), 32'd1);
    check("sim_d_rdata", d_rdata,       32'hCAFE0001);
    check("sim_if_gnt",  32'(if_gnt),   32'd1);
    check("sim_if_addr", mem_addr,      32'h300);
    step(); mem_rdata = 32'h0;
    sample();
    check("sim_if_gnt_c4",32'(if_gnt),  32'd0);
    step(); if_req = 1'b0; mem_rdata = 32'h0BADF00D;
    sample();
    check("sim_if_rvalid",32'(if_rvalid),32'd1);
    check("sim_if_rdata",if_rdata,      32'h0BADF00D);
    check("sim_d_rdata0",d_rdata,       32'd0);
    step(); idle_in();

    // Starvation: per-slot table, bit s is issue slot s+1 (slots are two cycles apart).
    s_ireq = 8'b0111_1111; s_dreq = 8'b0011_1111;
    s_dg   = 8'b0010_1111; s_ig   = 8'b0101_0000;
    s_dv   = 8'b0101_1110; s_iv   = 8'b1010_0000;
    for (int s = 0; s < 8; s++) begin
      step();
      if_req = s_ireq[s]; d_req = s_dreq[s];
      d_we = 1'b0; d_ctrl = MEM_W; d_addr = 32'h500;
      if_addr = (s >= 5) ? 32'h404 : 32'h400;
      sample();
      check($sformatf("stv_d_gnt_s%0d", s + 1),  32'(d_gnt),     32'(s_dg[s]));
      check($sformatf("stv_if_gnt_s%0d", s + 1), 32'(if_gnt),    32'(s_ig[s]));
      check($sformatf("stv_d_rv_s%0d", s + 1),   32'(d_rvalid),  32'(s_dv[s]));
      check($sformatf("stv_if_rv_s%0d", s + 1),  32'(if_rvalid), 32'(s_iv[s]));
      step(); sample();
      check($sformatf("stv_gap_gnt_s%0d", s + 1), 32'(d_gnt | if_gnt), 32'd0);
    end
    step(); idle_in();

    // Misaligned word load rejected, then an aligned halfword at the same address.
    step(); d_req = 1'b1; d_ctrl = MEM_W; d_addr = 32'h102;
    sample();
    check("mis_d_gnt",   32'(d_gnt),    32'd1);
    check("mis_mem_en",  32'(mem_en),   32'd0);
    check("mis_addr",    mem_addr,      32'd0);
    step(); d_ctrl = MEM_H;
    sample();
    check("mis_rvalid",  32'(d_rvalid), 32'd1);
    check("mis_err",     32'(d_err),    32'd1);
    check("mis_no_slot", 32'(d_gnt),    32'd0);
    check("mis_no_en",   32'(mem_en),   32'd0);
    step(); sample();
    check("lh_d_gnt",    32'(d_gnt),    32'd1);
    check("lh_mem_en",   32'(mem_en),   32'd1);
    check("lh_ctrl",     32'(mem_ctrl), 32'(MEM_H));
    check("lh_addr",     mem_addr,      32'h102);
    check("lh_err_c1",   32'(d_err),    32'd0);
    step(); sample();
    step(); d_req = 1'b0; mem_rdata = 32'h0000BEEF;
    sample();
    check("lh_rvalid",   32'(d_rvalid), 32'd1);
    check("lh_err",      32'(d_err),    32'd0);
    check("lh_rdata",    d_rdata,       32'h0000BEEF);
    step(); mem_rdata = 32'h0; d_req = 1'b1; d_ctrl = MEM_HU; d_addr = 32'h105;
    sample();
    check("mis_hu_gnt",  32'(d_gnt),    32'd1);
    check("mis_hu_en",   32'(mem_en),   32'd0);
    step(); d_req = 1'b0;
    sample();
    check("mis_hu_err",  32'(d_err),    32'd1);
    step(); idle_in();

    // Byte store.
    step(); d_req = 1'b1; d_we = 1'b1; d_ctrl = MEM_B; d_addr = 32'h3; d_wdata = 32'hAB;
    sample();
    check("sb_gnt",      32'(d_gnt),    32'd1);
    check("sb_en",       32'(mem_en),   32'd1);
    check("sb_we",       32'(mem_we),   32'd1);
    check("sb_ctrl",     32'(mem_ctrl), 32'(MEM_B));
    check("sb_addr",     mem_addr,      32'h3);
    check("sb_wdata",    mem_wdata,     32'hAB);
    step(); sample();
    check("sb_stall_c2", 32'(stall_d),  32'd1);
    step(); d_req = 1'b0;
    sample();
    check("sb_ack",      32'(d_rvalid), 32'd1);
    check("sb_stall_ack",32'(stall_d),  32'd0);
    step(); sample();
    check("sb_ack_off",  32'(d_rvalid), 32'd0);
    check("sb_stall_end",32'(stall_d),  32'd0);
    idle_in();

    // Reset while a fetch is outstanding.
    step(); if_req = 1'b1; if_addr = 32'h600;
    sample();
    check("rw_gnt",      32'(if_gnt),   32'd1);
    step(); rst_n = 1'b0;
    sample();
    check("rw_gnt_rst",  32'(if_gnt),   32'd0);
    check("rw_en_rst",   32'(mem_en),   32'd0);
    check("rw_rv_rst",   32'(if_rvalid),32'd0);
    check("rw_stall_rst",32'(stall_if), 32'd1);
    step(); rst_n = 1'b1; mem_rdata = 32'h55AA55AA;
    sample();
    check("rw_no_rv",    32'(if_rvalid),32'd0);
    check("rw_regnt",    32'(if_gnt),   32'd1);
    check("rw_addr",     mem_addr,      32'h600);
    step(); sample();
    check("rw_no_rv_c2", 32'(if_rvalid),32'd0);
    step(); if_req = 1'b0; mem_rdata = 32'h600D600D;
    sample();
    check("rw_rv",       32'(if_rvalid),32'd1);
    check("rw_rdata",    if_rdata,      32'h600D600D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
